// File: rtl/nebula_sw_alloc_if.sv
// Request/grant/credit bundle between the input stage of a nebula_router
// and its switch allocator.
interface nebula_sw_alloc_if #(
    parameter int PORTS = 5,
    parameter int VCS   = 4,
    parameter int PW    = $clog2(PORTS),
    parameter int VW    = $clog2(VCS)
);
    logic [PORTS-1:0]     req_valid;
    logic [PORTS*PW-1:0]  req_out;
    logic [PORTS*VW-1:0]  req_vc;
    logic [PORTS-1:0]     req_head;
    logic [PORTS-1:0]     req_tail;
    logic [PORTS*VCS-1:0] credit_in;
    logic [PORTS-1:0]     gnt;
    logic [PORTS-1:0]     out_valid;
    logic [PORTS*PW-1:0]  out_sel;
    logic [PORTS-1:0]     congest;
    logic                 err_credit;

    // Handshake: req_valid[i] holds a flit until gnt[i]; a flit is consumed in
    // exactly the cycle where req_valid[i] && gnt[i]. credit_in bits are
    // single-cycle pulses with no back-pressure.
    modport master (
        output req_valid, req_out, req_vc, req_head, req_tail, credit_in,
        input  gnt, out_valid, out_sel, congest, err_credit
    );

    modport slave (
        input  req_valid, req_out, req_vc, req_head, req_tail, credit_in,
        output gnt, out_valid, out_sel, congest, err_credit
    );
endinterface

// File: rtl/nebula_sw_alloc.sv
// Switch allocator with wormhole locking, per-output round-robin among heads
// and per-output/per-VC downstream credit counters.
module nebula_sw_alloc #(
    parameter int PORTS      = 5,
    parameter int VCS        = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int PW = $clog2(PORTS),
    localparam int VW = $clog2(VCS),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input logic clk,
    input logic rst_n,
    nebula_sw_alloc_if.slave bus
);

    logic             lock   [PORTS];
    logic [PW-1:0]    owner  [PORTS];
    logic [PW-1:0]    rr     [PORTS];
    logic [CW-1:0]    credit [PORTS][VCS];
    logic [PORTS-1:0] congest_q;
    logic             err_q;

    logic [PW-1:0]    req_out_a  [PORTS];
    logic [VW-1:0]    req_vc_a   [PORTS];
    logic [PORTS-1:0] elig       [PORTS];
    logic [PORTS-1:0] valid_c;
    logic [PW-1:0]    sel_c      [PORTS];
    logic [PORTS-1:0] gnt_c;
    logic [CW-1:0]    credit_nxt [PORTS][VCS];
    logic [PORTS-1:0] congest_nxt;
    logic             err_set;
    logic [PORTS*PW-1:0] out_sel_flat;

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            req_out_a[i] = bus.req_out[i*PW +: PW];
            req_vc_a[i]  = bus.req_vc[i*VW +: VW];
        end
    end

    // Locked outputs only listen to their owner's non-head flits; unlocked
    // outputs only accept heads, picked round-robin starting at rr[o].
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < PORTS; o++) begin
            valid_c[o] = 1'b0;
            sel_c[o]   = '0;
            elig[o]    = '0;
            for (int i = 0; i < PORTS; i++) begin
                if (bus.req_valid[i] && (int'(req_out_a[i]) == o) &&
                    (credit[o][req_vc_a[i]] != '0)) begin
                    if (lock[o])
                        elig[o][i] = (owner[o] == PW'(i)) && !bus.req_head[i];
                    else
                        elig[o][i] = bus.req_head[i];
                end
            end
            if (lock[o]) begin
                if (elig[o][owner[o]]) begin
                    valid_c[o] = 1'b1;
                    sel_c[o]   = owner[o];
                end
            end else begin
                for (int k = 0; k < PORTS; k++) begin
                    idx = int'(rr[o]) + k;
                    if (idx >= PORTS) idx = idx - PORTS;
                    if (!valid_c[o] && elig[o][idx]) begin
                        valid_c[o] = 1'b1;
                        sel_c[o]   = PW'(idx);
                    end
                end
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            gnt_c[i] = 1'b0;
            for (int o = 0; o < PORTS; o++)
                if (valid_c[o] && (sel_c[o] == PW'(i))) gnt_c[i] = 1'b1;
        end
    end

    // A grant and a returned credit on the same counter cancel out.
    always_comb begin
        logic dec;
        logic inc;
        dec         = 1'b0;
        inc         = 1'b0;
        err_set     = 1'b0;
        congest_nxt = '0;
        for (int o = 0; o < PORTS; o++) begin
            for (int v = 0; v < VCS; v++) begin
                dec = valid_c[o] && (req_vc_a[sel_c[o]] == VW'(v));
                inc = bus.credit_in[o*VCS + v];
                credit_nxt[o][v] = credit[o][v];
                if (inc && !dec) begin
                    if (credit[o][v] == CW'(FIFO_DEPTH))
                        err_set = 1'b1;
                    else
                        credit_nxt[o][v] = credit[o][v] + CW'(1);
                end else if (dec && !inc) begin
                    credit_nxt[o][v] = credit[o][v] - CW'(1);
                end
                if (credit_nxt[o][v] == '0) congest_nxt[o] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < PORTS; o++) begin
                lock[o]  <= 1'b0;
                owner[o] <= '0;
                rr[o]    <= '0;
                for (int v = 0; v < VCS; v++) credit[o][v] <= CW'(FIFO_DEPTH);
            end
            congest_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int o = 0; o < PORTS; o++) begin
                for (int v = 0; v < VCS; v++) credit[o][v] <= credit_nxt[o][v];
                if (valid_c[o]) begin
                    if (bus.req_head[sel_c[o]]) begin
                        rr[o] <= (sel_c[o] == PW'(PORTS-1)) ? '0 : sel_c[o] + PW'(1);
                        if (!bus.req_tail[sel_c[o]]) begin
                            lock[o]  <= 1'b1;
                            owner[o] <= sel_c[o];
                        end
                    end else if (bus.req_tail[sel_c[o]]) begin
                        lock[o] <= 1'b0;
                    end
                end
            end
            congest_q <= congest_nxt;
            if (err_set) err_q <= 1'b1;
        end
    end

    always_comb begin
        for (int o = 0; o < PORTS; o++) out_sel_flat[o*PW +: PW] = sel_c[o];
    end

    assign bus.gnt        = gnt_c;
    assign bus.out_valid  = valid_c;
    assign bus.out_sel    = out_sel_flat;
    assign bus.congest    = congest_q;
    assign bus.err_credit = err_q;

endmodule

// File: tb/tb_nebula_sw_alloc.sv
// Directed bench for nebula_sw_alloc: inputs change on the falling edge and
// combinational outputs are sampled 1 time unit later.
module tb_nebula_sw_alloc;
    localparam int PORTS      = 5;
    localparam int VCS        = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int PW         = $clog2(PORTS);
    localparam int VW         = $clog2(VCS);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    nebula_sw_alloc_if #(.PORTS(PORTS), .VCS(VCS)) bus ();

    nebula_sw_alloc #(.PORTS(PORTS), .VCS(VCS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic clear_req();
        bus.req_valid = '0;
        bus.req_out   = '0;
        bus.req_vc    = '0;
        bus.req_head  = '0;
        bus.req_tail  = '0;
        bus.credit_in = '0;
    endtask

    task automatic set_req(input int i, input int o, input int vc, input bit h, input bit t);
        bus.req_valid[i]          = 1'b1;
        bus.req_out[i*PW +: PW]   = PW'(o);
        bus.req_vc[i*VW +: VW]    = VW'(vc);
        bus.req_head[i]           = h;
        bus.req_tail[i]           = t;
    endtask

    function automatic logic [PW-1:0] sel_of(input int o);
        return bus.out_sel[o*PW +: PW];
    endfunction

    task automatic test_reset();
        clear_req();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.gnt !== 5'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 00000", bus.gnt); end
        checks++; if (bus.out_valid !== 5'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 00000", bus.out_valid); end
        checks++; if (bus.out_sel !== 15'b0) begin errors++; $display("FAIL reset_out_sel: got %h expected 0", bus.out_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.congest !== 5'b0) begin errors++; $display("FAIL reset_congest: got %b expected 00000", bus.congest); end
        checks++; if (bus.err_credit !== 1'b0) begin errors++; $display("FAIL reset_err_credit: got %b expected 0", bus.err_credit); end
    endtask

    task automatic test_single_flit();
        @(negedge clk); clear_req(); set_req(4, 2, 1, 1'b1, 1'b1); #1;
        checks++; if (bus.gnt !== 5'b10000) begin errors++; $display("FAIL single_gnt: got %b expected 10000", bus.gnt); end
        checks++; if (bus.out_valid !== 5'b00100) begin errors++; $display("FAIL single_out_valid: got %b expected 00100", bus.out_valid); end
        checks++; if (sel_of(2) !== 3'd4) begin errors++; $display("FAIL single_out_sel: got %0d expected 4", sel_of(2)); end
        // body flit on the now-unlocked output, plus an out-of-range request
        @(negedge clk); clear_req(); set_req(4, 2, 1, 1'b0, 1'b0); set_req(0, 6, 0, 1'b1, 1'b1); #1;
        checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL nolock_body_gnt: got %b expected 00000", bus.gnt); end
        checks++; if (bus.out_valid !== 5'b00000) begin errors++; $display("FAIL nolock_out_valid: got %b expected 00000", bus.out_valid); end
    endtask

    task automatic test_round_robin();
        logic [PW-1:0]    e;
        logic [PORTS-1:0] expv;
        exp_q = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); clear_req();
            set_req(0, 4, 0, 1'b1, 1'b1);
            set_req(1, 4, 0, 1'b1, 1'b1);
            set_req(3, 4, 0, 1'b1, 1'b1);
            #1;
            e = exp_q.pop_front();
            expv = '0; expv[e] = 1'b1;
            checks++; if (bus.gnt !== expv) begin errors++; $display("FAIL rr_gnt cycle %0d: got %b expected %b", c, bus.gnt, expv); end
            checks++; if (bus.out_valid !== 5'b10000) begin errors++; $display("FAIL rr_out_valid cycle %0d: got %b expected 10000", c, bus.out_valid); end
            checks++; if (sel_of(4) !== e) begin errors++; $display("FAIL rr_out_sel cycle %0d: got %0d expected %0d", c, sel_of(4), e); end
        end
    endtask

    task automatic test_wormhole();
        bit               v1 [6] = '{1, 1, 0, 1, 1, 0};
        bit               h1 [6] = '{1, 0, 0, 0, 0, 0};
        bit               t1 [6] = '{0, 0, 0, 0, 1, 0};
        logic [PORTS-1:0] eg [6] = '{5'b00010, 5'b00010, 5'b00000, 5'b00010, 5'b00010, 5'b00100};
        for (int s = 0; s < 6; s++) begin
            @(negedge clk); clear_req();
            if (v1[s]) set_req(1, 3, 2, h1[s], t1[s]);
            set_req(2, 3, 3, 1'b1, 1'b1);
            #1;
            checks++; if (bus.gnt !== eg[s]) begin errors++; $display("FAIL worm_gnt step %0d: got %b expected %b", s, bus.gnt, eg[s]); end
            checks++; if (bus.out_valid[3] !== (eg[s] != 5'b0)) begin errors++; $display("FAIL worm_out_valid step %0d: got %b expected %b", s, bus.out_valid[3], (eg[s] != 5'b0)); end
        end
    endtask

    task automatic test_credit();
        for (int c = 0; c < FIFO_DEPTH; c++) begin
            @(negedge clk); clear_req(); set_req(0, 1, 0, 1'b1, 1'b1); #1;
            checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL drain_gnt %0d: got %b expected 00001", c, bus.gnt); end
        end
        // A: counter at 0, request blocked, credit returned
        @(negedge clk); clear_req(); set_req(0, 1, 0, 1'b1, 1'b1); bus.credit_in[4] = 1'b1; #1;
        checks++; if (bus.congest !== 5'b00010) begin errors++; $display("FAIL empty_congest: got %b expected 00010", bus.congest); end
        checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL empty_gnt: got %b expected 00000", bus.gnt); end
        // B: returned credit usable next cycle
        @(negedge clk); clear_req(); set_req(0, 1, 0, 1'b1, 1'b1); #1;
        checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL refill_gnt: got %b expected 00001", bus.gnt); end
        checks++; if (bus.congest !== 5'b00000) begin errors++; $display("FAIL refill_congest: got %b expected 00000", bus.congest); end
        // C: back to 0, return one credit
        @(negedge clk); clear_req(); bus.credit_in[4] = 1'b1; #1;
        checks++; if (bus.congest !== 5'b00010) begin errors++; $display("FAIL reempty_congest: got %b expected 00010", bus.congest); end
        // D: grant and credit_in together on a counter of 1
        @(negedge clk); clear_req(); set_req(0, 1, 0, 1'b1, 1'b1); bus.credit_in[4] = 1'b1; #1;
        checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL simul_gnt: got %b expected 00001", bus.gnt); end
        checks++; if (bus.congest !== 5'b00000) begin errors++; $display("FAIL simul_pre_congest: got %b expected 00000", bus.congest); end
        // E: counter must still be 1
        @(negedge clk); clear_req(); set_req(0, 1, 0, 1'b1, 1'b1); #1;
        checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL simul_hold_gnt: got %b expected 00001", bus.gnt); end
        checks++; if (bus.congest !== 5'b00000) begin errors++; $display("FAIL simul_hold_congest: got %b expected 00000", bus.congest); end
        // F: now exhausted
        @(negedge clk); clear_req(); set_req(0, 1, 0, 1'b1, 1'b1); #1;
        checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL final_empty_gnt: got %b expected 00000", bus.gnt); end
        checks++; if (bus.congest !== 5'b00010) begin errors++; $display("FAIL final_empty_congest: got %b expected 00010", bus.congest); end
    endtask

    task automatic test_err_credit();
        @(negedge clk); clear_req(); bus.credit_in[2] = 1'b1; #1;
        checks++; if (bus.err_credit !== 1'b0) begin errors++; $display("FAIL err_before: got %b expected 0", bus.err_credit); end
        @(negedge clk); clear_req(); #1;
        checks++; if (bus.err_credit !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus.err_credit); end
        // counter must have held at FIFO_DEPTH: exactly that many grants fit
        for (int c = 0; c < FIFO_DEPTH; c++) begin
            @(negedge clk); clear_req(); set_req(3, 0, 2, 1'b1, 1'b1); #1;
            checks++; if (bus.gnt !== 5'b01000) begin errors++; $display("FAIL ovf_drain_gnt %0d: got %b expected 01000", c, bus.gnt); end
        end
        @(negedge clk); clear_req(); set_req(3, 0, 2, 1'b1, 1'b1); #1;
        checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL ovf_ninth_gnt: got %b expected 00000", bus.gnt); end
        checks++; if (bus.congest !== 5'b00011) begin errors++; $display("FAIL ovf_congest: got %b expected 00011", bus.congest); end
        checks++; if (bus.err_credit !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus.err_credit); end
    endtask

    task automatic test_reset_mid_packet();
        @(negedge clk); clear_req(); set_req(0, 2, 0, 1'b1, 1'b0); #1;
        checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL mid_head_gnt: got %b expected 00001", bus.gnt); end
        @(negedge clk); clear_req(); set_req(0, 2, 0, 1'b0, 1'b0); #1;
        checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL mid_body_gnt: got %b expected 00001", bus.gnt); end
        @(negedge clk); clear_req(); set_req(0, 2, 0, 1'b0, 1'b0); #1;
        checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL mid_body2_gnt: got %b expected 00001", bus.gnt); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL async_gnt: got %b expected 00000", bus.gnt); end
        checks++; if (bus.out_valid !== 5'b00000) begin errors++; $display("FAIL async_out_valid: got %b expected 00000", bus.out_valid); end
        checks++; if (bus.out_sel !== 15'b0) begin errors++; $display("FAIL async_out_sel: got %h expected 0", bus.out_sel); end
        checks++; if (bus.err_credit !== 1'b0) begin errors++; $display("FAIL async_err_credit: got %b expected 0", bus.err_credit); end
        checks++; if (bus.congest !== 5'b00000) begin errors++; $display("FAIL async_congest: got %b expected 00000", bus.congest); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL stale_body_gnt: got %b expected 00000", bus.gnt); end
        @(negedge clk); clear_req(); set_req(0, 2, 0, 1'b0, 1'b0); set_req(1, 2, 0, 1'b1, 1'b1); #1;
        checks++; if (bus.gnt !== 5'b00010) begin errors++; $display("FAIL new_head_gnt: got %b expected 00010", bus.gnt); end
        checks++; if (sel_of(2) !== 3'd1) begin errors++; $display("FAIL new_head_sel: got %0d expected 1", sel_of(2)); end
        for (int c = 0; c < FIFO_DEPTH; c++) begin
            @(negedge clk); clear_req(); set_req(0, 1, 0, 1'b1, 1'b1); #1;
            checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL post_reset_drain %0d: got %b expected 00001", c, bus.gnt); end
        end
        @(negedge clk); clear_req(); set_req(0, 1, 0, 1'b1, 1'b1); #1;
        checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL post_reset_ninth: got %b expected 00000", bus.gnt); end
        @(negedge clk); clear_req();
    endtask

    initial begin
        clear_req();
        test_reset();
        test_single_flit();
        test_round_robin();
        test_wormhole();
        test_credit();
        test_err_credit();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nebula_sw_alloc.md
Name: nebula_sw_alloc

Overview:
- Switch allocator and output-credit manager for one nebula_router instance.
- Every cycle it decides which input port drives each output port of the 5-port crossbar (N,S,E,W,Local).
- Tracks per-output, per-VC downstream credits.
- Enforces wormhole packet locking, so flits of different packets never interleave on one output.
- Round-robin fairness among competing head flits; sits between route compute / input VC FIFOs and the crossbar.

Parameters:
- PORTS, 5, number of router ports; index 0=N, 1=S, 2=E, 3=W, 4=Local.
- VCS, 4, virtual channels per link.
- FIFO_DEPTH, 8, downstream per-VC buffer depth; initial credit value.
- PW, $clog2(PORTS), width of a port index (derived).
- VW, $clog2(VCS), width of a VC index (derived).
- CW, $clog2(FIFO_DEPTH+1), credit counter width (derived).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  PORTS  input i presents a flit.
- req_out  in  PORTS*PW  requested output port of input i.
- req_vc  in  PORTS*VW  downstream VC targeted by input i.
- req_head  in  PORTS  flit is a packet head.
- req_tail  in  PORTS  flit is a packet tail; head and tail both set means a single-flit packet.
- credit_in  in  PORTS*VCS  pulse: downstream of output o freed one slot of VC v; bit o*VCS+v.
- gnt  out  PORTS  input i's flit crosses the switch this cycle; input pops it.
- out_valid  out  PORTS  output o carries a flit this cycle.
- out_sel  out  PORTS*PW  input index driving output o; 0 when out_valid[o]=0.
- congest  out  PORTS  output o has at least one VC with credit 0.
- err_credit  out  1  sticky: a credit was returned to a full counter.

Behaviour:
- Reset (async assert): all locks cleared, owners=0, rr pointers=0, every credit=FIFO_DEPTH, err_credit=0. gnt, out_valid and out_sel are 0 because nothing is locked and outputs are combinational from state. congest=0.
- Reset mid-packet: the locked packet is abandoned; upstream is responsible for flushing it.
- Latency: gnt, out_valid and out_sel are combinational from the current request inputs and the registered state (zero-cycle allocation). State updates on the following clock edge.
- Eligibility of input i for output o = req_valid[i] && req_out[i]==o && credit[o][req_vc[i]]>0 && one of:
  - (!lock[o] && req_head[i]);
  - (lock[o] && owner[o]==i && !req_head[i]).
- A non-head flit on an unlocked output is never granted.
- A head flit presented by the lock owner is never granted.
- req_out[i] >= PORTS: request ignored.
- Locked output: only owner[o] may be granted. If the owner's req_valid drops, output o idles and stays locked with no timeout.
- Unlocked output: winner is the first eligible input scanning rr[o], rr[o]+1, ... mod PORTS.
- Each input requests exactly one output, so gnt has at most one grant per input; gnt[i] = OR over o of (out_valid[o] && out_sel[o]==i).
- Lock update on grant of input i at output o:
  - head && !tail: lock[o]<=1, owner[o]<=i, rr[o]<=(i+1) mod PORTS.
  - head && tail: no lock; rr[o]<=(i+1) mod PORTS.
  - !head && tail: lock[o]<=0.
  - body flit: no change.
- rr[o] changes only on head grants.
- Credit update per (o,v):
  - decrement on a grant to VC v at output o;
  - increment on credit_in;
  - both in the same cycle: unchanged;
  - increment at FIFO_DEPTH: counter holds and err_credit<=1 (sticky until reset);
  - decrement at 0 cannot occur because eligibility requires credit>0.
- Credit returned in cycle t is usable for a grant in cycle t+1.
- congest[o] is registered: next value = OR over v of (next credit[o][v]==0).

Test Plan:
- Reset, then input 4 (Local) sends a 1-flit head+tail packet to E (o=2) on VC1 -> gnt[4]=1, out_valid[2]=1, out_sel[2]=4 in the same cycle; credit[2][1] 8->7; no lock.
- Inputs 0,1,3 all send single-flit heads to output 4 each cycle with rr[4]=0 -> grants in order 0,1,3,0,1,3; exactly one out_valid[4] per cycle.
- Input 1 sends a 4-flit packet to W while input 2 holds a head for W -> input 1 granted 4 consecutive cycles; input 2 granted in cycle 5. Insert a req_valid[1] bubble after flit 2 -> W idles and input 2 still blocked.
- Drain VC0 of output S: 8 single-flit grants with no credit_in -> the 9th request is not granted and congest[1]=1. Pulse credit_in for (S,VC0) -> grant in the next cycle. Simultaneous credit_in and grant -> counter unchanged.
- credit_in for (N,VC2) at credit 8 -> counter stays 8, err_credit=1 and remains 1 until rst_n.
- Assert rst_n=0 asynchronously mid 4-flit packet after flit 2 -> outputs 0 immediately. After release, a body flit from the old owner is not granted; a new head from another input is granted; all credits=8.
